// File: rtl/audio_pkg.sv
// Shared audio definitions for the FX chain: default sample width, stereo
// sample type and channel indices.
package audio_pkg;

  localparam int DATA_W_DEF = 16;

  localparam int LEFT  = 0;
  localparam int RIGHT = 1;

  typedef logic [1:0][DATA_W_DEF-1:0] stereo_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S clock master timing: BCLK divider, fall-event strobe, bit-slot counter
// and LRCLK. Outputs that the DAC sees are registered.
module i2s_clk_gen
  import audio_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int BCLK_DIV = 4,
  localparam int SLOT_W  = $clog2(2*DATA_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              bclk,
  output logic              lrclk,
  output logic              fall,
  output logic              load,
  output logic [SLOT_W-1:0] slot_nxt
);

  localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_nxt;
  logic [SLOT_W-1:0] slot;

  always_comb begin
    fall     = (div_cnt == DIV_W'(BCLK_DIV-1));
    div_nxt  = fall ? '0 : div_cnt + 1'b1;
    load     = fall && (slot == SLOT_W'(2*DATA_W-1));
    slot_nxt = slot;
    if (fall) begin
      slot_nxt = load ? '0 : slot + 1'b1;
    end
  end

  // bclk/lrclk are computed from next-state values so they switch on the
  // same edge as the counters (and as sdata in the top level).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      slot    <= SLOT_W'(2*DATA_W-1);
      bclk    <= 1'b0;
      lrclk   <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      slot    <= slot_nxt;
      bclk    <= (div_nxt >= DIV_W'(BCLK_DIV/2));
      lrclk   <= (slot_nxt >= SLOT_W'(DATA_W-1)) &&
                 (slot_nxt <= SLOT_W'(2*DATA_W-2));
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Stereo Philips-I2S transmitter (clock master) with a one-entry holding
// register fed by a valid/ready handshake; repeats the last frame on underrun.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int BCLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0][DATA_W-1:0] audio_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   bclk,
  output logic                   lrclk,
  output logic                   sdata,
  output logic                   underrun
);

  localparam int SLOT_W = $clog2(2*DATA_W);

  logic                   fall;
  logic                   load;
  logic [SLOT_W-1:0]      slot_nxt;
  logic [1:0][DATA_W-1:0] hold_data;
  logic                   hold_full;
  logic [1:0][DATA_W-1:0] last_data;
  logic [1:0][DATA_W-1:0] frame_src;
  logic                   accept;
  logic                   sdata_nxt;

  i2s_clk_gen #(
    .DATA_W   (DATA_W),
    .BCLK_DIV (BCLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .fall     (fall),
    .load     (load),
    .slot_nxt (slot_nxt)
  );

  // Bit for a given slot: left MSB-first in slots 0..DATA_W-1, then right.
  function automatic logic slot_bit(input logic [1:0][DATA_W-1:0] src,
                                    input logic [SLOT_W-1:0]      slot);
    logic [2*DATA_W-1:0] word;
    word = {src[LEFT], src[RIGHT]} << slot;
    return word[2*DATA_W-1];
  endfunction

  always_comb begin
    in_ready  = !hold_full;
    accept    = in_valid && !hold_full;
    frame_src = (load && hold_full) ? hold_data : last_data;
    sdata_nxt = slot_bit(frame_src, slot_nxt);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_data <= audio_in;
    end
  end

  // A sample accepted in the load cycle itself lands in the holding register
  // and waits for the next frame; the current frame underruns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full <= 1'b0;
      last_data <= '0;
      sdata     <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= load && !hold_full;
      if (load && hold_full) begin
        last_data <= hold_data;
      end
      if (fall) begin
        sdata <= sdata_nxt;
      end
      if (accept) begin
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx at DATA_W=16, BCLK_DIV=4 (128-cycle frames).
module tb_i2s_tx;

  localparam int DW  = 16;
  localparam int DIV = 4;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [1:0][DW-1:0] audio_in;
  logic               in_valid;
  logic               in_ready;
  logic               bclk;
  logic               lrclk;
  logic               sdata;
  logic               underrun;

  int checks = 0;
  int errors = 0;
  bit stream_on = 1'b0;
  int stream_k  = 0;
  int acc_cnt   = 0;

  always #5 clk = ~clk;

  i2s_tx #(.DATA_W(DW), .BCLK_DIV(DIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .audio_in (audio_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bclk     (bclk),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .underrun (underrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_audio(input logic [15:0] l, input logic [15:0] r);
    audio_in[0] = l;
    audio_in[1] = r;
  endtask

  task automatic tick();
    logic acc;
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      acc_cnt++;
      if (stream_on) begin
        stream_k++;
        set_audio(16'h1000 + 16'(stream_k), 16'h2000 + 16'(stream_k));
      end
    end
  endtask

  // Runs one frame starting just after a load edge and ending just after the
  // next one; captures sdata/lrclk on bclk rising edges.
  task automatic run_frame(input bit pulse, input logic [15:0] pl, input logic [15:0] pr,
                           output logic [31:0] data, output logic [31:0] lr,
                           output int und, output int low, output int acc);
    logic prev_b;
    int   nbits;
    int   a0;
    data = '0; lr = '0; und = 0; low = 0; nbits = 0; a0 = acc_cnt;
    for (int t = 1; t <= 128; t++) begin
      if (pulse && t == 128) begin
        set_audio(pl, pr);
        in_valid = 1'b1;
      end
      prev_b = bclk;
      tick();
      if (pulse && t == 128) in_valid = 1'b0;
      if (!prev_b && bclk) begin
        data = {data[30:0], sdata};
        lr   = {lr[30:0], lrclk};
        nbits++;
      end
      if (underrun) und++;
      if (!in_ready) low++;
    end
    acc = acc_cnt - a0;
    chk("bits_per_frame", nbits, 32);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] data, lr;
    int und, low, acc;

    reset_n  = 1'b0;
    in_valid = 1'b0;
    set_audio(16'h0000, 16'h0000);
    tick(); tick(); tick();
    chk1("rst_bclk", bclk, 1'b0);
    chk1("rst_lrclk", lrclk, 1'b0);
    chk1("rst_sdata", sdata, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_underrun", underrun, 1'b0);

    // Release with a sample already offered
    set_audio(16'hA5C3, 16'h3C5A);
    in_valid = 1'b1;
    reset_n  = 1'b1;
    tick();
    in_valid = 1'b0;
    chk1("c1_in_ready", in_ready, 1'b0);
    chk1("c1_bclk", bclk, 1'b0);
    tick();
    chk1("c2_bclk", bclk, 1'b1);
    tick();
    chk1("c3_bclk", bclk, 1'b1);
    tick();
    chk1("c4_bclk_fall", bclk, 1'b0);
    chk1("c4_sdata_msb", sdata, 1'b1);
    chk1("c4_lrclk", lrclk, 1'b0);
    chk1("c4_underrun", underrun, 1'b0);
    chk1("c4_in_ready", in_ready, 1'b1);

    // Frame 0: first sample; no new sample follows
    run_frame(1'b0, 16'h0, 16'h0, data, lr, und, low, acc);
    chk("f0_data", data, 32'hA5C3_3C5A);
    chk("f0_lrclk", lr, 32'h0001_FFFE);
    chk("f0_underrun_cnt", und, 1);

    // Frame 1: repeat; streaming starts
    stream_on = 1'b1;
    stream_k  = 0;
    set_audio(16'h1000, 16'h2000);
    in_valid  = 1'b1;
    run_frame(1'b0, 16'h0, 16'h0, data, lr, und, low, acc);
    chk("f1_data_repeat", data, 32'hA5C3_3C5A);
    chk("f1_lrclk", lr, 32'h0001_FFFE);
    chk("f1_underrun_cnt", und, 0);
    chk("f1_accepts", acc, 1);
    chk("f1_ready_low", low, 127);

    run_frame(1'b0, 16'h0, 16'h0, data, lr, und, low, acc);
    chk("f2_data", data, 32'h1000_2000);
    chk("f2_underrun_cnt", und, 0);
    chk("f2_accepts", acc, 1);
    chk("f2_ready_low", low, 127);

    run_frame(1'b0, 16'h0, 16'h0, data, lr, und, low, acc);
    stream_on = 1'b0;
    in_valid  = 1'b0;
    chk("f3_data", data, 32'h1001_2001);
    chk("f3_underrun_cnt", und, 0);
    chk("f3_accepts", acc, 1);

    run_frame(1'b0, 16'h0, 16'h0, data, lr, und, low, acc);
    chk("f4_data", data, 32'h1002_2002);
    chk("f4_underrun_cnt", und, 1);
    chk("f4_accepts", acc, 0);
    chk("f4_ready_low", low, 0);

    // Frame 5: sample offered exactly in the load cycle
    run_frame(1'b1, 16'h8001, 16'h7FFE, data, lr, und, low, acc);
    chk("f5_data_repeat", data, 32'h1002_2002);
    chk("f5_underrun_cnt", und, 1);
    chk("f5_accepts", acc, 1);
    chk1("f5_in_ready_after_load", in_ready, 1'b0);

    run_frame(1'b0, 16'h0, 16'h0, data, lr, und, low, acc);
    chk("f6_data_repeat", data, 32'h1002_2002);
    chk("f6_underrun_cnt", und, 0);

    run_frame(1'b0, 16'h0, 16'h0, data, lr, und, low, acc);
    chk("f7_data", data, 32'h8001_7FFE);
    chk("f7_lrclk", lr, 32'h0001_FFFE);
    chk("f7_underrun_cnt", und, 1);

    // Frame 8: hold a sample, then reset in the right channel (slot 20)
    set_audio(16'h1234, 16'h5678);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk1("f8_in_ready_held", in_ready, 1'b0);
    for (int i = 0; i < 81; i++) tick();
    chk1("pre_rst_bclk", bclk, 1'b1);
    chk1("pre_rst_lrclk", lrclk, 1'b1);
    chk1("pre_rst_sdata", sdata, 1'b1);
    reset_n = 1'b0;
    #1;
    chk1("mid_rst_bclk", bclk, 1'b0);
    chk1("mid_rst_lrclk", lrclk, 1'b0);
    chk1("mid_rst_sdata", sdata, 1'b0);
    chk1("mid_rst_in_ready", in_ready, 1'b1);
    chk1("mid_rst_underrun", underrun, 1'b0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk1("r1_bclk", bclk, 1'b0);
    tick();
    chk1("r2_bclk", bclk, 1'b1);
    tick();
    chk1("r3_bclk", bclk, 1'b1);
    tick();
    chk1("r4_bclk_fall", bclk, 1'b0);
    chk1("r4_underrun", underrun, 1'b1);
    chk1("r4_sdata", sdata, 1'b0);
    chk1("r4_lrclk", lrclk, 1'b0);
    chk1("r4_in_ready", in_ready, 1'b1);
    tick();
    chk1("r5_underrun_done", underrun, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Stereo I2S transmitter at the output end of the FX chain. It accepts one stereo sample per frame from the last effect stage through a valid/ready handshake. It serializes the sample MSB-first onto standard Philips I2S lines (BCLK, LRCLK, SDATA) toward the DAC. BCLK and LRCLK are generated internally from `clk`, so the block is the I2S clock master.

## Interface
Parameters:
- `DATA_W`, 16: bits per channel; one frame is 2*DATA_W BCLK periods.
- `BCLK_DIV`, 4: `clk` cycles per BCLK period; must be even and ≥2.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `audio_in`  in  [1:0][DATA_W-1:0]  stereo sample; [0]=left, [1]=right; two's complement.
- `in_valid`  in  1  `audio_in` is valid.
- `in_ready`  out  1  the block can accept a sample.
- `bclk`  out  1  I2S bit clock.
- `lrclk`  out  1  word select; 0=left, 1=right.
- `sdata`  out  1  serial data; changes on the BCLK falling edge.
- `underrun`  out  1  one-cycle pulse when a frame starts with no new sample.

## Operation
- `div_cnt` counts 0..BCLK_DIV-1 and wraps.
  - `bclk` is registered: 1 when `div_cnt` ≥ BCLK_DIV/2, else 0.
  - A "fall event" is the cycle in which `div_cnt` wraps from BCLK_DIV-1 to 0.
- Slot counter `p` runs 0..2*DATA_W-1. It advances only on a fall event and wraps from 2*DATA_W-1 to 0.
- `lrclk` is registered: 1 for p in [DATA_W-1, 2*DATA_W-2], 0 otherwise. This gives the standard one-BCLK lead before each MSB.
- `sdata`:
  - p in 0..DATA_W-1: `left[DATA_W-1-p]`.
  - p in DATA_W..2*DATA_W-1: `right[2*DATA_W-1-p]`.
- Holding register (one stereo entry) with `hold_full` flag:
  - `in_ready` = !`hold_full`.
  - When `in_valid` && `in_ready`: store `audio_in` and set `hold_full`.
- Frame load happens on the fall event where p wraps to 0:
  - If `hold_full`: copy the holding register to the shift/last-sample register and clear `hold_full`.
  - If empty: retransmit the last-sample register unchanged and pulse `underrun` for one `clk` cycle.
- Simultaneous accept and load with the holding register empty: the accepted sample goes into the holding register. It is not sent this frame; that frame underruns and the sample is sent next frame.
- `in_ready` is deasserted from the load cycle onward only if a new sample is written. A full holding register cannot be overwritten.
- Reset asserted at any time, including mid-frame, immediately forces all state to reset values. No partial frame completes.

## Timing
- Reset values:
  - `div_cnt`=0, p=2*DATA_W-1, `bclk`=0, `lrclk`=0, `sdata`=0.
  - `hold_full`=0, so `in_ready`=1.
  - Last-sample register=0, `underrun`=0.
- `bclk`, `lrclk` and `sdata` are all registered and update on the same `clk` edge. On a fall event all three change together with `bclk` going 1→0.
- The first fall event occurs BCLK_DIV cycles after reset release and loads frame 0.
- Frame period is 2*DATA_W*BCLK_DIV `clk` cycles (128 at the defaults).
- Latency: a sample accepted at cycle t appears as the left MSB on `sdata` at the next frame-load fall event after t. That is at most one frame period plus BCLK_DIV cycles.
- Throughput: one sample per frame. `in_ready` rises in the cycle after each load.

## Structure
- Shared `audio_pkg` holds:
  - the `DATA_W` default;
  - typedef `stereo_t` as [1:0][DATA_W-1:0];
  - channel index constants LEFT=0 and RIGHT=1.
- Sub-module `i2s_clk_gen` (divider, `bclk`, fall-event strobe, slot counter, `lrclk`).
- Top-level `i2s_tx` holds the holding register, shift/last-sample register and output mux.

## Test plan
All scenarios use DATA_W=16 and BCLK_DIV=4.
- Reset release → `bclk`=`lrclk`=`sdata`=0 and `in_ready`=1. First `bclk` 1→0 occurs 4 cycles after release; `bclk` toggles every 2 cycles thereafter.
- Accept L=0xA5C3, R=0x3C5A before the first load → the 32 `sdata` bits captured on `bclk` rising edges are 0xA5C3 then 0x3C5A. `lrclk` is 0 for 15 bits, 1 for 16 bits, then 0 again, with transitions one BCLK before each MSB.
- No sample supplied for frame 2 → `underrun` pulses exactly once, for one cycle, at the load, and frame 2 repeats 0xA5C3/0x3C5A.
- Hold `in_valid` high continuously with incrementing data → exactly one sample is accepted per 128 cycles, no sample is skipped or duplicated, and `in_ready` is low between accept and load.
- Assert `in_valid` exactly on the load cycle with the holding register empty → `underrun` pulses, and that sample is transmitted in the following frame.
- Assert `reset_n` low mid-right-channel → all outputs go to reset values immediately. After release, the sequence restarts with the first fall event at cycle 4, and the pre-reset held sample is lost (`in_ready`=1).
